// File: rtl/m_muldiv_iter.sv
// m_muldiv_iter: iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, both on operand
// magnitudes, retiring UNROLL bits per cycle. A sign fix is applied when the
// result is registered. Division by zero and signed overflow skip the
// iteration and complete in one cycle.
module m_muldiv_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int ITER = XLEN / UNROLL;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;

    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [XLEN-1:0]   hi_nxt, lo_nxt, div_val, final_res;
    logic [XLEN:0]     sum_v, shift_v, diff_v;
    logic [2*XLEN-1:0] prod_v;

    // A request is taken only in IDLE, and a simultaneous flush wins over it.
    assign accept = i_valid & o_ready & ~i_flush;

    // Decode the incoming request: operand signedness, magnitudes, result sign and the one-cycle special cases.
    always_comb begin
        a_signed    = (i_op == OP_MULH) | (i_op == OP_MULHSU) | (i_op == OP_DIV) | (i_op == OP_REM);
        b_signed    = (i_op == OP_MULH) | (i_op == OP_DIV) | (i_op == OP_REM);
        a_neg       = a_signed & i_rs1[XLEN-1];
        b_neg       = b_signed & i_rs2[XLEN-1];
        a_mag       = a_neg ? (~i_rs1 + 1'b1) : i_rs1;
        b_mag       = b_neg ? (~i_rs2 + 1'b1) : i_rs2;
        neg_in      = (i_op[2] & i_op[1]) ? a_neg : (a_neg ^ b_neg);
        special     = 1'b0;
        special_res = '0;
        if (i_op[2] && (i_rs2 == '0)) begin
            special     = 1'b1;
            special_res = i_op[1] ? i_rs1 : '1;
        end else if (((i_op == OP_DIV) || (i_op == OP_REM)) && (i_rs1 == SMIN) && (i_rs2 == '1)) begin
            special     = 1'b1;
            special_res = i_op[1] ? '0 : SMIN;
        end
    end

    // Retire UNROLL bits: restoring-division steps for DIV/REM, shift-add steps for the multiplies.
    always_comb begin
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
        sum_v   = '0;
        shift_v = '0;
        diff_v  = '0;
        for (int k = 0; k < UNROLL; k++) begin
            if (op_q[2]) begin
                shift_v = {hi_nxt, lo_nxt[XLEN-1]};
                diff_v  = shift_v - {1'b0, b_q};
                hi_nxt  = diff_v[XLEN] ? shift_v[XLEN-1:0] : diff_v[XLEN-1:0];
                lo_nxt  = {lo_nxt[XLEN-2:0], ~diff_v[XLEN]};
            end else begin
                sum_v   = {1'b0, hi_nxt} + (lo_nxt[0] ? {1'b0, b_q} : '0);
                hi_nxt  = sum_v[XLEN:1];
                lo_nxt  = {sum_v[0], lo_nxt[XLEN-1:1]};
            end
        end
    end

    // Apply the sign fix and pick the requested half or the quotient/remainder from the last step.
    always_comb begin
        prod_v    = {hi_nxt, lo_nxt};
        if (neg_q) begin
            prod_v = ~prod_v + 1'b1;
        end
        div_val   = op_q[1] ? hi_nxt : lo_nxt;
        if (neg_q) begin
            div_val = ~div_val + 1'b1;
        end
        final_res = div_val;
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? prod_v[XLEN-1:0] : prod_v[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush) begin
            state_nxt = IDLE;
        end
    end

    // Datapath registers: load on accept, iterate in CALC, capture the result on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (i_flush) begin
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        op_q  <= i_op;
                        neg_q <= neg_in;
                        hi_q  <= '0;
                        lo_q  <= i_op[2] ? a_mag : b_mag;
                        b_q   <= i_op[2] ? b_mag : a_mag;
                        if (special) begin
                            result_q <= special_res;
                        end
                    end
                end
                CALC: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        result_q <= final_res;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Handshake outputs follow the state; o_ready is forced low while reset is asserted.
    always_comb begin
        o_ready  = (state == IDLE) & rst_n;
        o_valid  = (state == DONE);
        o_result = result_q;
    end

endmodule
